// File: rtl/mem_access_arbiter_if.sv
// Bundle of the CPU and loader request ports plus the data-memory port.
// req/ack: a requester holds req (with stable attributes) until ack pulses for one cycle, then drops req.
interface mem_access_arbiter_if;
    logic        CPU_req;
    logic        CPU_we;
    logic [1:0]  CPU_length;
    logic        CPU_signed;
    logic [31:0] CPU_addr;
    logic [31:0] CPU_wdata;
    logic        CPU_ack;
    logic        CPU_err;
    logic [31:0] CPU_rdata;

    logic        LD_req;
    logic        LD_we;
    logic [1:0]  LD_length;
    logic        LD_signed;
    logic [31:0] LD_addr;
    logic [31:0] LD_wdata;
    logic        LD_ack;
    logic        LD_err;
    logic [31:0] LD_rdata;

    logic [1:0]  MEM_write_length;
    logic [1:0]  MEM_read_length;
    logic        MEM_read_signed;
    logic [31:0] MEM_write_address;
    logic [31:0] MEM_read_address;
    logic [31:0] MEM_write_data;
    logic [31:0] MEM_read_data;

    modport slave (
        input  CPU_req, CPU_we, CPU_length, CPU_signed, CPU_addr, CPU_wdata,
        output CPU_ack, CPU_err, CPU_rdata,
        input  LD_req, LD_we, LD_length, LD_signed, LD_addr, LD_wdata,
        output LD_ack, LD_err, LD_rdata,
        output MEM_write_length, MEM_read_length, MEM_read_signed,
        output MEM_write_address, MEM_read_address, MEM_write_data,
        input  MEM_read_data
    );

    modport master (
        output CPU_req, CPU_we, CPU_length, CPU_signed, CPU_addr, CPU_wdata,
        input  CPU_ack, CPU_err, CPU_rdata,
        output LD_req, LD_we, LD_length, LD_signed, LD_addr, LD_wdata,
        input  LD_ack, LD_err, LD_rdata,
        input  MEM_write_length, MEM_read_length, MEM_read_signed,
        input  MEM_write_address, MEM_read_address, MEM_write_data,
        output MEM_read_data
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter between the CPU pipeline and the loader for one data memory.
// Each access runs IDLE -> ACCESS -> RESP; misaligned or out-of-range requests are rejected.
module mem_access_arbiter #(
    parameter int MEM_BYTES = 100
) (
    input  logic                 SYS_clk,
    input  logic                 SYS_reset,
    mem_access_arbiter_if.slave  bus,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        grant;
    logic        grant_ld;
    logic        last_ld;
    logic        lat_ld;
    logic        lat_we;
    logic        lat_signed;
    logic [1:0]  lat_len;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] cpu_rdata;
    logic [31:0] ld_rdata;
    logic [2:0]  size;
    logic [32:0] end_addr;
    logic        err;
    logic        active;

    always_comb begin
        grant     = 1'b0;
        grant_ld  = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.CPU_req || bus.LD_req) begin
                    grant     = 1'b1;
                    // On a tie the loader wins only if the CPU held the last grant.
                    grant_ld  = bus.LD_req && (!bus.CPU_req || !last_ld);
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        size = 3'd0;
        case (lat_len)
            2'b01:   size = 3'd1;
            2'b10:   size = 3'd2;
            2'b11:   size = 3'd4;
            default: size = 3'd0;
        endcase
        end_addr = {1'b0, lat_addr} + {30'd0, size} - 33'd1;
        err = (lat_len == 2'b00)
            || (lat_len == 2'b10 && lat_addr[0])
            || (lat_len == 2'b11 && lat_addr[1:0] != 2'b00)
            || (end_addr >= 33'(MEM_BYTES));
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state      <= IDLE;
            last_ld    <= 1'b1;
            lat_ld     <= 1'b0;
            lat_we     <= 1'b0;
            lat_signed <= 1'b0;
            lat_len    <= 2'b00;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            cpu_rdata  <= 32'd0;
            ld_rdata   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                lat_ld     <= grant_ld;
                last_ld    <= grant_ld;
                lat_we     <= grant_ld ? bus.LD_we     : bus.CPU_we;
                lat_len    <= grant_ld ? bus.LD_length : bus.CPU_length;
                lat_signed <= grant_ld ? bus.LD_signed : bus.CPU_signed;
                lat_addr   <= grant_ld ? bus.LD_addr   : bus.CPU_addr;
                lat_wdata  <= grant_ld ? bus.LD_wdata  : bus.CPU_wdata;
            end
            // Rejected requests of either kind leave the port's rdata at zero.
            if (state == ACCESS && (!lat_we || err)) begin
                if (lat_ld) ld_rdata  <= err ? 32'd0 : bus.MEM_read_data;
                else        cpu_rdata <= err ? 32'd0 : bus.MEM_read_data;
            end
        end
    end

    // Reset gates the memory port so a store caught in ACCESS never lands.
    assign active = (state == ACCESS) && !err && !SYS_reset;

    always_comb begin
        bus.MEM_write_length  = (active && lat_we)  ? lat_len    : 2'b00;
        bus.MEM_write_address = (active && lat_we)  ? lat_addr   : 32'd0;
        bus.MEM_write_data    = (active && lat_we)  ? lat_wdata  : 32'd0;
        bus.MEM_read_length   = (active && !lat_we) ? lat_len    : 2'b00;
        bus.MEM_read_address  = (active && !lat_we) ? lat_addr   : 32'd0;
        bus.MEM_read_signed   = (active && !lat_we) ? lat_signed : 1'b0;
        bus.CPU_ack   = (state == RESP) && !lat_ld && !SYS_reset;
        bus.LD_ack    = (state == RESP) &&  lat_ld && !SYS_reset;
        bus.CPU_err   = bus.CPU_ack && err;
        bus.LD_err    = bus.LD_ack && err;
        bus.CPU_rdata = cpu_rdata;
        bus.LD_rdata  = ld_rdata;
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized bench for mem_access_arbiter: byte-array memory device, reference model and scoreboard.
module tb_mem_access_arbiter;
    localparam int MEM_BYTES = 100;

    typedef struct packed {
        logic        we;
        logic [1:0]  len;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] cyc;
    } exp_t;

    typedef struct packed {
        logic [1:0]  wl;
        logic [1:0]  rl;
        logic        rs;
        logic [31:0] wa;
        logic [31:0] ra;
        logic [31:0] wd;
    } memexp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         cpu_acks = 0;
    int         ld_acks = 0;

    logic [7:0]  dev_mem [MEM_BYTES] = '{default: 8'h00};
    logic [7:0]  ref_mem [MEM_BYTES] = '{default: 8'h00};
    logic        m_last_ld = 1'b1;
    logic [31:0] m_rdata [2] = '{32'd0, 32'd0};
    exp_t        exp_q [$];
    memexp_t     mem_q [$];

    mem_access_arbiter_if bus();

    mem_access_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .SYS_clk   (clk),
        .SYS_reset (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic int nbytes(input logic [1:0] len);
        case (len)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] assemble(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3,
                                             input logic [1:0] len, input logic sgn);
        case (len)
            2'b01:   return {{24{sgn & b0[7]}}, b0};
            2'b10:   return {{16{sgn & b1[7]}}, b1, b0};
            2'b11:   return {b3, b2, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [7:0] dev_byte(input logic [31:0] a);
        if (a < 32'(MEM_BYTES)) return dev_mem[int'(a)];
        return 8'h00;
    endfunction

    function automatic bit is_err(input op_t o);
        if (o.len == 2'b00) return 1'b1;
        if (o.len == 2'b10 && o.addr % 2 != 0) return 1'b1;
        if (o.len == 2'b11 && o.addr % 4 != 0) return 1'b1;
        return (longint'(o.addr) + longint'(nbytes(o.len)) - 1) >= longint'(MEM_BYTES);
    endfunction

    function automatic op_t mk(input logic we, input logic [1:0] len, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
        op_t o;
        o.we = we; o.len = len; o.sgn = sgn; o.addr = addr; o.wdata = wdata;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.we    = 1'($urandom_range(0, 1));
        o.len   = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        o.sgn   = 1'($urandom_range(0, 1));
        o.wdata = $urandom;
        if ($urandom_range(0, 3) == 0) begin
            o.addr = 32'($urandom_range(0, MEM_BYTES + 3));
        end else begin
            o.addr = 32'($urandom_range(0, MEM_BYTES - 1));
            if (o.len == 2'b11) o.addr[1:0] = 2'b00;
            if (o.len == 2'b10) o.addr[0] = 1'b0;
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ---------------- memory device ----------------
    always_comb begin
        bus.MEM_read_data = assemble(dev_byte(bus.MEM_read_address),
                                     dev_byte(bus.MEM_read_address + 32'd1),
                                     dev_byte(bus.MEM_read_address + 32'd2),
                                     dev_byte(bus.MEM_read_address + 32'd3),
                                     bus.MEM_read_length, bus.MEM_read_signed);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (k < nbytes(bus.MEM_write_length) && int'(bus.MEM_write_address) + k < MEM_BYTES)
                dev_mem[int'(bus.MEM_write_address) + k] <= bus.MEM_write_data[8*k +: 8];
        end
    end

    // ---------------- reference model ----------------
    task automatic model_service(input logic port, input op_t o, input int ack_cyc);
        memexp_t m;
        exp_t    e;
        bit      bad;
        bad = is_err(o);
        m = '0;
        if (!bad) begin
            if (o.we) begin
                for (int k = 0; k < nbytes(o.len); k++)
                    ref_mem[int'(o.addr) + k] = o.wdata[8*k +: 8];
                m.wl = o.len; m.wa = o.addr; m.wd = o.wdata;
            end else begin
                m_rdata[port] = assemble(ref_mem[int'(o.addr)],
                                         (nbytes(o.len) > 1) ? ref_mem[int'(o.addr) + 1] : 8'h00,
                                         (nbytes(o.len) > 2) ? ref_mem[int'(o.addr) + 2] : 8'h00,
                                         (nbytes(o.len) > 2) ? ref_mem[int'(o.addr) + 3] : 8'h00,
                                         o.len, o.sgn);
                m.rl = o.len; m.ra = o.addr; m.rs = o.sgn;
            end
            mem_q.push_back(m);
        end else begin
            m_rdata[port] = 32'd0;
        end
        e.port = port; e.err = bad; e.rdata = m_rdata[port]; e.cyc = 32'(ack_cyc);
        exp_q.push_back(e);
        m_last_ld = port;
    endtask

    // ---------------- driver ----------------
    task automatic drive_port(input logic port, input op_t o);
        if (!port) begin
            bus.CPU_we = o.we; bus.CPU_length = o.len; bus.CPU_signed = o.sgn;
            bus.CPU_addr = o.addr; bus.CPU_wdata = o.wdata;
        end else begin
            bus.LD_we = o.we; bus.LD_length = o.len; bus.LD_signed = o.sgn;
            bus.LD_addr = o.addr; bus.LD_wdata = o.wdata;
        end
    endtask

    task automatic do_round(input bit c_en, input op_t c_op, input bit l_en, input op_t l_op);
        int   start, c_base, l_base;
        logic first;
        bit   done;
        @(posedge clk); #1;
        start = cyc;
        if (c_en && l_en) begin
            first = m_last_ld ? 1'b0 : 1'b1;
            model_service(first, first ? l_op : c_op, start + 2);
            model_service(!first, first ? c_op : l_op, start + 5);
        end else begin
            first = l_en;
            model_service(first, first ? l_op : c_op, start + 2);
        end
        c_base = cpu_acks; l_base = ld_acks;
        if (c_en) begin drive_port(1'b0, c_op); bus.CPU_req = 1'b1; end
        if (l_en) begin drive_port(1'b1, l_op); bus.LD_req = 1'b1; end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            // The winner is in ACCESS now; its latched copy must not follow the pins.
            if (i == 0) drive_port(first, rnd_op());
            if (c_en && cpu_acks != c_base) bus.CPU_req = 1'b0;
            if (l_en && ld_acks != l_base) bus.LD_req = 1'b0;
            done = (!c_en || cpu_acks != c_base) && (!l_en || ld_acks != l_base);
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL ack_timeout actual=no_ack required=ack");
            bus.CPU_req = 1'b0; bus.LD_req = 1'b0;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t    e;
        memexp_t m;
        if (bus.MEM_write_length != 2'b00 || bus.MEM_read_length != 2'b00) begin
            if (mem_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL mem_unexpected actual=wl%0d_rl%0d required=idle",
                         bus.MEM_write_length, bus.MEM_read_length);
            end else begin
                m = mem_q.pop_front();
                check("mem_wlen", 64'(bus.MEM_write_length), 64'(m.wl));
                check("mem_rlen", 64'(bus.MEM_read_length), 64'(m.rl));
                check("mem_waddr", 64'(bus.MEM_write_address), 64'(m.wa));
                check("mem_raddr", 64'(bus.MEM_read_address), 64'(m.ra));
                check("mem_wdata", 64'(bus.MEM_write_data), 64'(m.wd));
                check("mem_rsigned", 64'(bus.MEM_read_signed), 64'(m.rs));
            end
        end else begin
            check("mem_idle_zero", {bus.MEM_write_address, bus.MEM_read_address | bus.MEM_write_data
                                    | 32'(bus.MEM_read_signed)}, 64'd0);
        end
        if (bus.CPU_ack && bus.LD_ack) begin
            checks++; failures++;
            $display("FAIL dual_ack actual=both required=one");
        end
        if ((bus.CPU_err && !bus.CPU_ack) || (bus.LD_err && !bus.LD_ack)) begin
            checks++; failures++;
            $display("FAIL err_without_ack actual=%0b%0b required=00", bus.CPU_err, bus.LD_err);
        end
        if (bus.CPU_ack) cpu_acks++;
        if (bus.LD_ack) ld_acks++;
        if (bus.CPU_ack || bus.LD_ack) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL ack_unexpected actual=ack cpu=%0b ld=%0b required=none",
                         bus.CPU_ack, bus.LD_ack);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", 64'(bus.LD_ack), 64'(e.port));
                check("ack_err", 64'(bus.LD_ack ? bus.LD_err : bus.CPU_err), 64'(e.err));
                check("ack_rdata", 64'(bus.LD_ack ? bus.LD_rdata : bus.CPU_rdata), 64'(e.rdata));
                check("ack_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int mode;
        bus.CPU_req = 1'b0; bus.LD_req = 1'b0;
        drive_port(1'b0, '0);
        drive_port(1'b1, '0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_acks", {62'd0, bus.CPU_ack, bus.LD_ack}, 64'd0);
        check("reset_rdata", {bus.CPU_rdata, bus.LD_rdata}, 64'd0);
        check("reset_mem_len", 64'({bus.MEM_write_length, bus.MEM_read_length}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Simultaneous requests right after reset: CPU, LD, CPU, LD.
        do_round(1, mk(0, 2'b11, 0, 32'd0, 0), 1, mk(0, 2'b11, 0, 32'd4, 0));
        do_round(1, mk(0, 2'b11, 0, 32'd12, 0), 1, mk(0, 2'b10, 0, 32'd16, 0));

        // Word store/load round trip.
        do_round(1, mk(1, 2'b11, 0, 32'd8, 32'hDEADBEEF), 0, '0);
        do_round(1, mk(0, 2'b11, 0, 32'd8, 0), 0, '0);

        // Byte sign extension.
        do_round(0, '0, 1, mk(1, 2'b01, 0, 32'd3, 32'h00000080));
        do_round(1, mk(0, 2'b01, 1, 32'd3, 0), 0, '0);
        do_round(0, '0, 1, mk(0, 2'b01, 0, 32'd3, 0));

        // Rejected and boundary accesses.
        do_round(0, '0, 1, mk(1, 2'b11, 0, 32'd2, 32'h11111111));
        do_round(0, '0, 1, mk(1, 2'b10, 0, 32'd5, 32'h22222222));
        do_round(0, '0, 1, mk(1, 2'b11, 0, 32'd97, 32'h33333333));
        do_round(0, '0, 1, mk(1, 2'b00, 0, 32'd8, 32'h44444444));
        do_round(0, '0, 1, mk(0, 2'b11, 0, 32'd100, 0));
        do_round(0, '0, 1, mk(0, 2'b10, 1, 32'd99, 0));
        do_round(0, '0, 1, mk(1, 2'b11, 0, 32'd96, 32'hA5A55A5A));
        do_round(1, mk(0, 2'b11, 0, 32'd96, 0), 0, '0);
        do_round(1, mk(0, 2'b01, 1, 32'd99, 0), 0, '0);
        do_round(1, mk(0, 2'b11, 0, 32'd8, 0), 0, '0);

        // Reset during the ACCESS cycle of a store to address 0 aborts it.
        @(posedge clk); #1;
        drive_port(1'b0, mk(1, 2'b11, 0, 32'd0, 32'h12345678));
        bus.CPU_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.CPU_req = 1'b0;
        m_last_ld = 1'b1;
        m_rdata[0] = 32'd0;
        m_rdata[1] = 32'd0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_rdata_cleared", {bus.CPU_rdata, bus.LD_rdata}, 64'd0);
        do_round(1, mk(0, 2'b10, 0, 32'd0, 0), 0, '0);
        do_round(1, mk(0, 2'b01, 0, 32'd1, 0), 1, mk(0, 2'b01, 0, 32'd2, 0));

        // Randomized traffic.
        for (int r = 0; r < 150; r++) begin
            mode = $urandom_range(0, 2);
            do_round(mode != 1, rnd_op(), mode != 0, rnd_op());
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("mem_q_drained", 64'(mem_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
